// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART byte
// serializer between NUM_REQ requesters, with one registered output stage.
// Optional feature macro: UART_ARB_TIMEOUT_EN enables a forced release of
// the lock after TIMEOUT_CYCLES idle cycles inside a packet.
//
// Handshake (both sides): a byte moves on a cycle where valid and ready are
// both high. Senders hold valid and the payload stable until that cycle;
// ready never depends on the same-cycle valid of the sender it serves.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2700000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_pulse,
  output logic                       stateDbg
);

  localparam int IdW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [IdW-1:0]   rrPtr;
  logic [IdW-1:0]   rrNext;
  logic [IdW-1:0]   grantNext;
  logic [IdW-1:0]   pickIdx;
  logic [IdW-1:0]   nextId;
  logic [IdW:0]     candSum;
  logic             found;
  logic             readyGrant;
  logic             accept;
  logic [7:0]       grantByte;

  // Elaboration-time guard on the parameter ranges the design supports.
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : gBadParams
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  // Successor of the current owner, wrapping at NUM_REQ (not a power of two in general).
  assign nextId    = (grant_id == IdW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign grantByte = req_data[{grant_id, 3'b000} +: 8];
  assign busy      = (state == XFER);
  assign stateDbg  = state;

  // Round-robin search: first valid requester at or above rrPtr, wrapping.
  always_comb begin
    pickIdx = rrPtr;
    found   = 1'b0;
    candSum = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      candSum = {1'b0, rrPtr} + (IdW + 1)'(k);
      if (candSum >= (IdW + 1)'(NUM_REQ)) begin
        candSum = candSum - (IdW + 1)'(NUM_REQ);
      end
      if (!found && req_valid[candSum[IdW-1:0]]) begin
        found   = 1'b1;
        pickIdx = candSum[IdW-1:0];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES);
  logic [CntW-1:0] idleCnt;
  logic            timeoutHit;
`endif

  // Next-state, grant bookkeeping and the single per-requester ready line.
  always_comb begin
    stateNext  = state;
    grantNext  = grant_id;
    rrNext     = rrPtr;
    req_ready  = '0;
    readyGrant = 1'b0;
    accept     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    timeoutHit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req_valid) begin
          grantNext = pickIdx;
          stateNext = XFER;
        end
      end
      XFER: begin
        // Only take a byte when the output slot is empty or draining now,
        // so a waiting byte is never overwritten.
        readyGrant          = !tx_valid || tx_ready;
        req_ready[grant_id] = readyGrant;
        accept              = req_valid[grant_id] && readyGrant;
        if (accept && req_last[grant_id]) begin
          stateNext = IDLE;
          rrNext    = nextId;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (!req_valid[grant_id] && idleCnt == CntW'(TIMEOUT_CYCLES - 1)) begin
          stateNext  = IDLE;
          rrNext     = nextId;
          timeoutHit = 1'b1;
        end
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_id <= '0;
      rrPtr    <= '0;
    end else begin
      state    <= stateNext;
      grant_id <= grantNext;
      rrPtr    <= rrNext;
    end
  end

  // Output byte register; drains to the serializer independently of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if (accept) begin
      tx_valid <= 1'b1;
      tx_data  <= grantByte;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  // Idle counter within a packet and the one-cycle forced-release pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idleCnt       <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= timeoutHit;
      if (state != XFER || accept || timeoutHit) begin
        idleCnt <= '0;
      end else if (!req_valid[grant_id]) begin
        idleCnt <= idleCnt + 1'b1;
      end
    end
  end
`else
  assign timeout_pulse = 1'b0;
`endif

endmodule
